// File: rtl/srl.sv
// Registered logical right shifter: a log-depth barrel of SHAMT_W mux levels
// feeding one output register stage, with a synchronous active-low reset.
module srl #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [XLEN-1:0]    rs1,
  input  logic [SHAMT_W-1:0] rs2,
  output logic [XLEN-1:0]    result,
  output logic               out_valid
);

  logic [XLEN-1:0] lvl [0:SHAMT_W];
  logic [XLEN-1:0] result_d;
  logic [XLEN-1:0] result_q;
  logic            out_valid_d;
  logic            out_valid_q;

  assign lvl[0] = rs1;

  // Level k moves the word right by 2^k and zero-fills the vacated MSBs.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_level
    localparam int SH = 1 << k;
    assign lvl[k+1] = rs2[k] ? {{SH{1'b0}}, lvl[k][XLEN-1:SH]} : lvl[k];
  end

  // Next-state: result loads only on valid cycles; valid just follows in_valid.
  always_comb begin
    result_d    = result_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      result_d = lvl[SHAMT_W];
    end else begin
      result_d = result_q;
    end
  end

  // Output register stage; reset wins over a simultaneous valid input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= {XLEN{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_srl.sv
// Self-checking bench for srl: directed vector table, a reset-glitch sequence,
// and a randomized sweep against a bit-level reference of the zero-fill shift.
module tb_srl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] rs1;
  logic [4:0]  rs2;
  logic [31:0] result;
  logic        out_valid;

  int vectors;
  int miscompares;

  srl #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .rs1       (rs1),
    .rs2       (rs2),
    .result    (result),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        in_valid;
    logic [31:0] rs1;
    logic [4:0]  rs2;
    logic [31:0] exp_result;
    logic        exp_valid;
  } vec_t;

  vec_t tbl [0:12];

  task automatic check(input string name, input logic [31:0] exp_r, input logic exp_v);
    vectors++;
    if (result !== exp_r || out_valid !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got result=%08h out_valid=%b, want result=%08h out_valid=%b",
               name, result, out_valid, exp_r, exp_v);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] a, input logic [4:0] s);
    rst_n    = r;
    in_valid = v;
    rs1      = a;
    rs2      = s;
  endtask

  // Reference: bit b of the result is rs1 bit b+sh when that exists, else 0.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int sh);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) begin
      r[b] = (b + sh < 32) ? a[b + sh] : 1'b0;
    end
    return r;
  endfunction

  logic [31:0] m_result;
  logic        m_valid;
  logic        r_rst;
  logic        r_v;
  logic [31:0] r_a;
  logic [4:0]  r_s;

  initial begin
    vectors     = 0;
    miscompares = 0;
    drive(1'b0, 1'b0, 32'h0, 5'd0);

    tbl[0]  = '{1'b0, 1'b0, 32'h0000_0000, 5'd0,  32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 32'h8000_0000, 5'd0,  32'h8000_0000, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 32'h8000_0000, 5'd1,  32'h4000_0000, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 32'hF000_F000, 5'd8,  32'h00F0_00F0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 32'h0000_0001, 5'd31, 32'h0000_0000, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 32'hFFFF_FFFF, 5'd16, 32'h0000_FFFF, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 32'hDEAD_BEEF, 5'd3,  32'h0000_FFFF, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h1357_9BDF, 5'd0,  32'h0000_FFFF, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 5'd1,  32'h0000_FFFF, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 32'h1234_5678, 5'd4,  32'h0000_0000, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 32'h1234_5678, 5'd4,  32'h0123_4567, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 32'h8000_0001, 5'd31, 32'h0000_0001, 1'b1};

    for (int i = 0; i <= 12; i++) begin
      drive(tbl[i].rst_n, tbl[i].in_valid, tbl[i].rs1, tbl[i].rs2);
      @(posedge clk);
      #1;
      check($sformatf("table[%0d]", i), tbl[i].exp_result, tbl[i].exp_valid);
    end

    // A reset pulse entirely between edges must not disturb anything.
    drive(1'b1, 1'b1, 32'hA5A5_A5A5, 5'd0);
    @(posedge clk);
    #1;
    check("glitch_load", 32'hA5A5_A5A5, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 5'd0);
    #2 rst_n = 1'b0;
    #1 check("glitch_mid", 32'hA5A5_A5A5, 1'b1);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("glitch_hold", 32'hA5A5_A5A5, 1'b0);

    // Mid-stream reset discards the in-flight op; next op has normal latency.
    drive(1'b1, 1'b1, 32'hCAFE_F00D, 5'd12);
    @(posedge clk);
    #1;
    check("stream_a", 32'h000C_AFEF, 1'b1);
    drive(1'b0, 1'b1, 32'hFFFF_0000, 5'd2);
    @(posedge clk);
    #1;
    check("stream_rst", 32'h0000_0000, 1'b0);
    drive(1'b1, 1'b1, 32'h8765_4321, 5'd20);
    @(posedge clk);
    #1;
    check("stream_b", 32'h0000_0876, 1'b1);

    // Randomized sweep: every shift amount visited repeatedly.
    m_result = result;
    m_valid  = out_valid;
    for (int i = 0; i < 320; i++) begin
      r_rst = ($urandom_range(0, 31) != 0);
      r_v   = ($urandom_range(0, 3) != 0);
      r_a   = $urandom;
      r_s   = 5'(i % 32);
      drive(r_rst, r_v, r_a, r_s);
      if (!r_rst) begin
        m_result = 32'h0;
        m_valid  = 1'b0;
      end else begin
        m_valid = r_v;
        if (r_v) begin
          m_result = ref_shift(r_a, i % 32);
        end
      end
      @(posedge clk);
      #1;
      check($sformatf("rand[%0d] rs1=%08h rs2=%0d", i, r_a, r_s), m_result, m_valid);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/srl.md
SRL -- requirements
Module: srl

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data width of rs1 and result.
REQ-002 Parameter SHAMT_W, default 5, SHALL set the width of rs2 and SHALL equal log2(XLEN).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the synchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit, SHALL mark rs1/rs2 as a valid operation in the current cycle.
REQ-006 Port rs1, input, XLEN bits, SHALL be the operand to shift.
REQ-007 Port rs2, input, SHAMT_W bits, SHALL be the unsigned shift amount, 0..XLEN-1.
REQ-008 Port result, output, XLEN bits, registered, SHALL be the shifted operand.
REQ-009 Port out_valid, output, 1 bit, registered, SHALL mark result as valid.

Function
REQ-010 The block SHALL compute a logical right shift: result = rs1 >> rs2, vacated MSBs filled with 0, never sign-extended.
REQ-011 The shift SHALL be a log-depth barrel structure of SHAMT_W mux levels; level k shifts by 2^k when rs2[k]=1, otherwise passes through.
REQ-012 Only the low SHAMT_W bits SHALL determine the shift amount; no other masking or saturation.
REQ-013 rs2 = 0 SHALL return rs1 unchanged.
REQ-014 rs2 = XLEN-1 SHALL return rs1[XLEN-1] in bit 0 and zeros elsewhere.
REQ-015 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on result/out_valid after edge N.
REQ-016 out_valid SHALL equal in_valid registered one cycle earlier.
REQ-017 result SHALL load the shifted value only on edges where in_valid=1; on edges with in_valid=0 it SHALL hold its previous value.
REQ-018 Back-to-back valid inputs SHALL be accepted every cycle with no stall or backpressure (throughput 1/cycle).
REQ-019 Outputs SHALL depend only on registered state; no combinational path from inputs to outputs.
REQ-020 X/unknown input bits SHALL NOT propagate into out_valid; out_valid depends only on in_valid and rst_n.

Reset
REQ-021 When rst_n=0 at a rising edge, result SHALL become 0 and out_valid SHALL become 0 after that edge, regardless of in_valid.
REQ-022 Reset SHALL take priority over a simultaneous valid input; that operation SHALL be discarded.
REQ-023 Reset asserted mid-stream SHALL discard the in-flight result; the first valid input after rst_n returns to 1 SHALL produce its result with the normal 1-cycle latency.
REQ-024 The block SHALL have no asynchronous reset path; rst_n changes between edges SHALL have no effect on outputs.

Verification
REQ-025 rs1=0x80000000, rs2=0, in_valid=1 -> next cycle result=0x80000000, out_valid=1.
REQ-026 rs1=0x80000000 with rs2=1 then rs2=4, consecutive cycles -> results 0x40000000 then 0x08000000 on consecutive cycles, out_valid held at 1.
REQ-027 rs1=0xF000F000, rs2=8 -> result=0x00F000F0 (no sign fill); rs1=0x00000001, rs2=31 -> result=0x00000000.
REQ-028 Valid op (rs1=0xFFFFFFFF, rs2=16) then in_valid=0 for 3 cycles -> result=0x0000FFFF held for all 3 cycles, out_valid=1 then 0,0,0.
REQ-029 rst_n=0 on the same edge as in_valid=1 -> result=0, out_valid=0 next cycle; release rst_n and send rs1=0x12345678, rs2=4 -> result=0x01234567 one cycle later.
REQ-030 Randomised sweep of rs1 and all rs2 in 0..31, compared against a zero-filling reference shift -> zero mismatches.
